aes_encipher_block: RTL and testbench



---
 rtl/aes_encipher_block.sv | 129 ++++++++++++
 tb/tb_aes_encipher_block.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encipher_block.sv
// rtl/aes_encipher_block.sv - iterative AES encipher datapath, one round per clock
// Round keys are fetched externally by index on o_round; expansion is not done here.

module aes_sbox (
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_data = SBOX[i_data];
endmodule

module aes_encipher_block #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic [127:0] block,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [127:0] new_block,
    output logic         ready
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] MAIN      = 2'd1;
    localparam logic [1:0] FINAL     = 2'd2;
    localparam logic [3:0] LAST_MAIN = 4'(NUM_ROUNDS - 1);

    logic [127:0] r_state;
    logic [127:0] r_new_block;
    logic [3:0]   r_round;
    logic [1:0]   r_fsm;
    logic         r_ready;

    logic [127:0] w_sub;
    logic [127:0] w_shift;
    logic [127:0] w_mix;

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] b);
        return gm2(b) ^ b;
    endfunction

    // Byte i sits at row i%4, column i/4; ShiftRows pulls row r from column c+r.
    for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
        localparam int R = gi % 4;
        localparam int C = gi / 4;
        localparam int SRC = 4 * ((C + R) % 4) + R;

        aes_sbox u_sbox (
            .i_data(r_state[127-8*gi -: 8]),
            .o_data(w_sub[127-8*gi -: 8])
        );

        assign w_shift[127-8*gi -: 8] = w_sub[127-8*SRC -: 8];
    end

    for (genvar gc = 0; gc < 4; gc++) begin : g_cols
        logic [7:0] w_a0, w_a1, w_a2, w_a3;

        assign w_a0 = w_shift[127-32*gc -: 8];
        assign w_a1 = w_shift[119-32*gc -: 8];
        assign w_a2 = w_shift[111-32*gc -: 8];
        assign w_a3 = w_shift[103-32*gc -: 8];

        assign w_mix[127-32*gc -: 32] = {
            gm2(w_a0) ^ gm3(w_a1) ^ w_a2      ^ w_a3,
            w_a0      ^ gm2(w_a1) ^ gm3(w_a2) ^ w_a3,
            w_a0      ^ w_a1      ^ gm2(w_a2) ^ gm3(w_a3),
            gm3(w_a0) ^ w_a1      ^ w_a2      ^ gm2(w_a3)
        };
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= 128'h0;
            r_new_block <= 128'h0;
            r_round     <= 4'd0;
            r_fsm       <= IDLE;
            r_ready     <= 1'b1;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (next) begin
                        r_state <= block ^ round_key;
                        r_round <= 4'd1;
                        r_ready <= 1'b0;
                        r_fsm   <= MAIN;
                    end
                end
                MAIN: begin
                    r_state <= w_mix ^ round_key;
                    r_round <= r_round + 4'd1;
                    if (r_round == LAST_MAIN) begin
                        r_fsm <= FINAL;
                    end
                end
                FINAL: begin
                    r_new_block <= w_shift ^ round_key;
                    r_round     <= 4'd0;
                    r_ready     <= 1'b1;
                    r_fsm       <= IDLE;
                end
                default: begin
                    r_round <= 4'd0;
                    r_ready <= 1'b1;
                    r_fsm   <= IDLE;
                end
            endcase
        end
    end

    assign round     = r_round;
    assign new_block = r_new_block;
    assign ready     = r_ready;
endmodule

// File: tb/tb_aes_encipher_block.sv
// tb/tb_aes_encipher_block.sv - FIPS-197 vector bench for aes_encipher_block (AES-128 and AES-256)

module tb_aes_encipher_block;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         next10 = 1'b0, next14 = 1'b0;
    logic [127:0] block10 = 128'h0, block14 = 128'h0;
    logic [3:0]   round10, round14;
    logic [127:0] round_key10, round_key14;
    logic [127:0] new_block10, new_block14;
    logic         ready10, ready14;

    logic [127:0] rkb  [0:15];
    logic [127:0] rkc1 [0:15];
    logic [127:0] rk14 [0:15];
    logic [127:0] xk   [0:15];
    logic         sel_c1 = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // Bench-side key memory: the DUT's round index selects the key.
    assign round_key10 = sel_c1 ? rkc1[round10] : rkb[round10];
    assign round_key14 = rk14[round14];

    aes_encipher_block #(.NUM_ROUNDS(10)) dut10 (
        .clk(clk), .reset(reset), .next(next10), .block(block10), .round(round10),
        .round_key(round_key10), .new_block(new_block10), .ready(ready10)
    );

    aes_encipher_block #(.NUM_ROUNDS(14)) dut14 (
        .clk(clk), .reset(reset), .next(next14), .block(block14), .round(round14),
        .round_key(round_key14), .new_block(new_block14), .ready(ready14)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] v = 8'h01;
        if (x == 8'h00) v = 8'h00;
        else for (int k = 0; k < 254; k++) v = gmul(v, x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nk);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        int nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= nr) xk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else xk[r] = 128'h0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_vec++;
        if (ready10 !== 1'b1 || round10 !== 4'd0 || new_block10 !== 128'h0) begin
            n_err++;
            $display("FAIL reset_dut10: got ready=%b round=%0d nb=%h want 1/0/0", ready10, round10, new_block10);
        end
        n_vec++;
        if (ready14 !== 1'b1 || round14 !== 4'd0 || new_block14 !== 128'h0) begin
            n_err++;
            $display("FAIL reset_dut14: got ready=%b round=%0d nb=%h want 1/0/0", ready14, round14, new_block14);
        end
        step();
        n_vec++;
        if (ready10 !== 1'b1 || round10 !== 4'd0) begin
            n_err++;
            $display("FAIL reset_idle_hold: got ready=%b round=%0d want 1/0", ready10, round10);
        end
    endtask

    task automatic test_fips_b();
        sel_c1 = 1'b0;
        n_vec++;
        if (ready10 !== 1'b1) begin
            n_err++;
            $display("FAIL b_ready_start: got %b want 1", ready10);
        end
        next10 = 1'b1;
        block10 = PT_B;
        step();
        next10 = 1'b0;
        block10 = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 1; k <= 10; k++) begin
            n_vec++;
            if (round10 !== 4'(k) || ready10 !== 1'b0) begin
                n_err++;
                $display("FAIL b_round_seq: got round=%0d ready=%b want %0d/0", round10, ready10, k);
            end
            step();
        end
        n_vec++;
        if (ready10 !== 1'b1 || round10 !== 4'd0) begin
            n_err++;
            $display("FAIL b_done: got ready=%b round=%0d want 1/0", ready10, round10);
        end
        n_vec++;
        if (new_block10 !== CT_B) begin
            n_err++;
            $display("FAIL b_ciphertext: got %h want %h", new_block10, CT_B);
        end
    endtask

    task automatic test_fips_c1();
        sel_c1 = 1'b1;
        next10 = 1'b1;
        block10 = PT_C;
        step();
        next10 = 1'b0;
        block10 = ~PT_C;
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) begin
                n_vec++;
                if (new_block10 !== CT_B) begin
                    n_err++;
                    $display("FAIL c1_hold_prev: got %h want %h", new_block10, CT_B);
                end
            end
            step();
        end
        n_vec++;
        if (ready10 !== 1'b1 || new_block10 !== CT_C1) begin
            n_err++;
            $display("FAIL c1_ciphertext: got ready=%b nb=%h want 1/%h", ready10, new_block10, CT_C1);
        end
    endtask

    task automatic test_fips_c3();
        next14 = 1'b1;
        block14 = PT_C;
        step();
        next14 = 1'b0;
        block14 = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 1; k <= 14; k++) begin
            n_vec++;
            if (round14 !== 4'(k) || ready14 !== 1'b0) begin
                n_err++;
                $display("FAIL c3_round_seq: got round=%0d ready=%b want %0d/0", round14, ready14, k);
            end
            step();
        end
        n_vec++;
        if (ready14 !== 1'b1 || round14 !== 4'd0 || new_block14 !== CT_C3) begin
            n_err++;
            $display("FAIL c3_ciphertext: got ready=%b round=%0d nb=%h want 1/0/%h",
                     ready14, round14, new_block14, CT_C3);
        end
    endtask

    task automatic test_busy_ignore();
        sel_c1 = 1'b1;
        next10 = 1'b1;
        block10 = PT_C;
        step();
        for (int e = 1; e <= 11; e++) begin
            n_vec++;
            if (ready10 !== (e == 11)) begin
                n_err++;
                $display("FAIL busy_ready_edge%0d: got %b want %b", e, ready10, e == 11);
            end
            next10 = (e == 3 || e == 7);
            block10 = PT_B;
            if (e < 11) step();
        end
        next10 = 1'b0;
        n_vec++;
        if (new_block10 !== CT_C1 || round10 !== 4'd0) begin
            n_err++;
            $display("FAIL busy_result: got nb=%h round=%0d want %h/0", new_block10, round10, CT_C1);
        end
    endtask

    task automatic test_back_to_back();
        sel_c1 = 1'b0;
        next10 = 1'b1;
        block10 = PT_B;
        step();
        for (int e = 1; e <= 11; e++) begin
            n_vec++;
            if (ready10 !== (e == 11)) begin
                n_err++;
                $display("FAIL b2b_first_ready_edge%0d: got %b want %b", e, ready10, e == 11);
            end
            if (e < 11) step();
        end
        n_vec++;
        if (new_block10 !== CT_B) begin
            n_err++;
            $display("FAIL b2b_first_result: got %h want %h", new_block10, CT_B);
        end
        sel_c1 = 1'b1;
        block10 = PT_C;
        step();
        next10 = 1'b0;
        for (int e = 1; e <= 11; e++) begin
            n_vec++;
            if (ready10 !== (e == 11)) begin
                n_err++;
                $display("FAIL b2b_second_ready_edge%0d: got %b want %b", e, ready10, e == 11);
            end
            if (e == 1 || e == 10) begin
                n_vec++;
                if (new_block10 !== CT_B) begin
                    n_err++;
                    $display("FAIL b2b_hold_edge%0d: got %h want %h", e, new_block10, CT_B);
                end
            end
            if (e < 11) step();
        end
        n_vec++;
        if (new_block10 !== CT_C1 || round10 !== 4'd0) begin
            n_err++;
            $display("FAIL b2b_second_result: got nb=%h round=%0d want %h/0", new_block10, round10, CT_C1);
        end
    endtask

    task automatic test_reset_mid_op();
        sel_c1 = 1'b1;
        next10 = 1'b1;
        block10 = PT_C;
        next14 = 1'b1;
        block14 = PT_C;
        step();
        next10 = 1'b0;
        next14 = 1'b0;
        for (int k = 0; k < 4; k++) step();
        reset = 1'b1;
        step();
        n_vec++;
        if (ready10 !== 1'b1 || round10 !== 4'd0 || new_block10 !== 128'h0) begin
            n_err++;
            $display("FAIL midreset_dut10: got ready=%b round=%0d nb=%h want 1/0/0", ready10, round10, new_block10);
        end
        n_vec++;
        if (ready14 !== 1'b1 || round14 !== 4'd0 || new_block14 !== 128'h0) begin
            n_err++;
            $display("FAIL midreset_dut14: got ready=%b round=%0d nb=%h want 1/0/0", ready14, round14, new_block14);
        end
        reset = 1'b0;
        step();
        n_vec++;
        if (ready10 !== 1'b1 || round10 !== 4'd0 || new_block10 !== 128'h0) begin
            n_err++;
            $display("FAIL postreset_dut10: got ready=%b round=%0d nb=%h want 1/0/0", ready10, round10, new_block10);
        end
        n_vec++;
        if (ready14 !== 1'b1 || round14 !== 4'd0 || new_block14 !== 128'h0) begin
            n_err++;
            $display("FAIL postreset_dut14: got ready=%b round=%0d nb=%h want 1/0/0", ready14, round14, new_block14);
        end
    endtask

    initial begin
        expand_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
        for (int r = 0; r < 16; r++) rkb[r] = xk[r];
        expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        for (int r = 0; r < 16; r++) rkc1[r] = xk[r];
        expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
        for (int r = 0; r < 16; r++) rk14[r] = xk[r];

        test_reset();
        test_fips_b();
        test_fips_c1();
        test_fips_c3();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_op();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
